// File: rtl/alu_issue.sv
// Issue/capture front end: hands one request at a time to the 4-bit ALU and returns {ah,al} as a tagged response.
// Latency: accept to rsp_valid is ALU_LAT+1 cycles; back-to-back accepts are ALU_LAT+2 cycles apart.
// Backpressure: rsp_ready low holds the response and blocks new requests; req_ready follows rsp_ready only in RESP.
module alu_issue #(
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_opcode,
    input  logic [3:0]       req_b,
    input  logic [3:0]       req_c,
    input  logic [TAG_W-1:0] req_tag,
    output logic [2:0]       opcode,
    output logic [3:0]       b,
    output logic [3:0]       c,
    input  logic [3:0]       ah,
    input  logic [3:0]       al,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [2:0]       rsp_opcode,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [7:0]       done_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Cycles still to wait once in WAIT; the 4-bit counter covers the full 0..15 latency range.
    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         opcode_q, opcode_d;
    logic [3:0]         b_q, b_d;
    logic [3:0]         c_q, c_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [7:0]         rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_opcode_q, rsp_opcode_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic [7:0]         done_q, done_d;
    logic               accept;

    // Handshake decode from registered state; rsp_ready is the only input reaching req_ready.
    always_comb begin
        req_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        accept    = req_valid && req_ready;
    end

    assign opcode     = opcode_q;
    assign b          = b_q;
    assign c          = c_q;
    assign rsp_result = rsp_result_q;
    assign rsp_opcode = rsp_opcode_q;
    assign rsp_tag    = rsp_tag_q;
    assign done_count = done_q;

    // Next-state: count down the ALU latency, capture the result, then offer it until taken.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opcode_d     = opcode_q;
        b_d          = b_q;
        c_d          = c_q;
        tag_d        = tag_q;
        rsp_result_d = rsp_result_q;
        rsp_opcode_d = rsp_opcode_q;
        rsp_tag_d    = rsp_tag_q;
        done_d       = done_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = {ah, al};
                    rsp_opcode_d = opcode_q;
                    rsp_tag_d    = tag_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    done_d  = done_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accepting overrides the IDLE return so a waiting request goes straight back to WAIT.
        if (accept) begin
            opcode_d = req_opcode;
            b_d      = req_b;
            c_d      = req_c;
            tag_d    = req_tag;
            cnt_d    = LAT_CNT;
            state_d  = S_WAIT;
        end
    end

    // State register; synchronous reset drops any in-flight operation and clears everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            opcode_q     <= 3'd0;
            b_q          <= 4'd0;
            c_q          <= 4'd0;
            tag_q        <= '0;
            rsp_result_q <= 8'd0;
            rsp_opcode_q <= 3'd0;
            rsp_tag_q    <= '0;
            done_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opcode_q     <= opcode_d;
            b_q          <= b_d;
            c_q          <= c_d;
            tag_q        <= tag_d;
            rsp_result_q <= rsp_result_d;
            rsp_opcode_q <= rsp_opcode_d;
            rsp_tag_q    <= rsp_tag_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: three instances (ALU_LAT = 1, 0, 15), each with a stub ALU (ah=b, al=c delayed).
// A timing-level reference model predicts every output each cycle from accept times and handshakes.
// Directed sequences cover single op, back-to-back, backpressure, reset mid-op, counter wrap; then random traffic.
module tb_alu_issue;

    localparam int NI = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset      [NI];
    logic       req_valid  [NI];
    logic       req_ready  [NI];
    logic [2:0] req_opcode [NI];
    logic [3:0] req_b      [NI];
    logic [3:0] req_c      [NI];
    logic [3:0] req_tag    [NI];
    logic [2:0] opcode     [NI];
    logic [3:0] b          [NI];
    logic [3:0] c          [NI];
    logic [3:0] ah         [NI];
    logic [3:0] al         [NI];
    logic       rsp_valid  [NI];
    logic       rsp_ready  [NI];
    logic [7:0] rsp_result [NI];
    logic [2:0] rsp_opcode [NI];
    logic [3:0] rsp_tag    [NI];
    logic       busy       [NI];
    logic [7:0] done_count [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 15);

        alu_issue #(.ALU_LAT(LAT), .TAG_W(4)) u_dut (
            .clock      (clock),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_opcode (req_opcode[g]),
            .req_b      (req_b[g]),
            .req_c      (req_c[g]),
            .req_tag    (req_tag[g]),
            .opcode     (opcode[g]),
            .b          (b[g]),
            .c          (c[g]),
            .ah         (ah[g]),
            .al         (al[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_result (rsp_result[g]),
            .rsp_opcode (rsp_opcode[g]),
            .rsp_tag    (rsp_tag[g]),
            .busy       (busy[g]),
            .done_count (done_count[g])
        );

        // Stub ALU: result is {b,c}, delayed by LAT register stages (combinational for LAT=0).
        if (LAT == 0) begin : g_comb
            assign ah[g] = b[g];
            assign al[g] = c[g];
        end else begin : g_pipe
            logic [7:0] pipe [LAT];
            always_ff @(posedge clock) begin
                pipe[0] <= {b[g], c[g]};
                for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
            end
            assign {ah[g], al[g]} = pipe[LAT-1];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cur_i = 0;
    int cur_L = 0;

    // Reference model: one outstanding op, its age in edges since accept, and what the outputs must show.
    bit         m_pend;
    int         m_age;
    logic [7:0] m_done;
    logic [2:0] m_op;
    logic [3:0] m_b, m_c, m_tag;
    logic [2:0] m_alu_op;
    logic [3:0] m_alu_b, m_alu_c;
    logic [7:0] m_rres;
    logic [2:0] m_rop;
    logic [3:0] m_rtag;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (lat %0d): got %0h, expected %0h", tag, cur_L, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = 1'b0;
        m_age    = 0;
        m_done   = 8'd0;
        m_alu_op = 3'd0;
        m_alu_b  = 4'd0;
        m_alu_c  = 4'd0;
        m_rres   = 8'd0;
        m_rop    = 3'd0;
        m_rtag   = 4'd0;
    endtask

    // One cycle: compare all outputs against the model, drive new inputs, advance the model past the next edge.
    task automatic step(input bit rs, input bit rv, input logic [2:0] op, input logic [3:0] bb,
                        input logic [3:0] cc, input logic [3:0] tg, input bit rr, output bit acc);
        bit exp_rv, rdy, hs;
        @(negedge clock);
        exp_rv = m_pend && (m_age >= cur_L + 1);
        chk("rsp_valid",  32'(rsp_valid[cur_i]),  32'(exp_rv));
        chk("req_ready",  32'(req_ready[cur_i]),  32'(!m_pend || (exp_rv && rsp_ready[cur_i])));
        chk("busy",       32'(busy[cur_i]),       32'(m_pend));
        chk("done_count", 32'(done_count[cur_i]), 32'(m_done));
        chk("alu_opcode", 32'(opcode[cur_i]),     32'(m_alu_op));
        chk("alu_b",      32'(b[cur_i]),          32'(m_alu_b));
        chk("alu_c",      32'(c[cur_i]),          32'(m_alu_c));
        chk("rsp_result", 32'(rsp_result[cur_i]), 32'(m_rres));
        chk("rsp_opcode", 32'(rsp_opcode[cur_i]), 32'(m_rop));
        chk("rsp_tag",    32'(rsp_tag[cur_i]),    32'(m_rtag));

        reset[cur_i]      = rs;
        req_valid[cur_i]  = rv;
        req_opcode[cur_i] = op;
        req_b[cur_i]      = bb;
        req_c[cur_i]      = cc;
        req_tag[cur_i]    = tg;
        rsp_ready[cur_i]  = rr;
        #1;
        rdy = !m_pend || (exp_rv && rr);
        chk("req_ready_comb", 32'(req_ready[cur_i]), 32'(rdy));

        acc = 1'b0;
        if (rs) begin
            model_reset();
        end else begin
            hs  = exp_rv && rr;
            acc = rv && rdy;
            if (hs) begin
                m_done = m_done + 8'd1;
                m_pend = 1'b0;
            end else if (m_pend) begin
                m_age++;
                if (m_age == cur_L + 1) begin
                    m_rres = {m_b, m_c};
                    m_rop  = m_op;
                    m_rtag = m_tag;
                end
            end
            if (acc) begin
                m_pend   = 1'b1;
                m_age    = 0;
                m_op     = op;
                m_b      = bb;
                m_c      = cc;
                m_tag    = tg;
                m_alu_op = op;
                m_alu_b  = bb;
                m_alu_c  = cc;
            end
        end
    endtask

    task automatic idle(input bit rr);
        bit acc;
        step(1'b0, 1'b0, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), rr, acc);
    endtask

    task automatic reset_cycle();
        bit acc;
        step(1'b1, 1'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), acc);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] bb, input logic [3:0] cc,
                         input logic [3:0] tg, input bit rr);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 64 && !acc; k++) step(1'b0, 1'b1, op, bb, cc, tg, rr, acc);
        chk("issue_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 40 && rsp_valid[cur_i] !== 1'b1; k++) idle(1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && m_pend; k++) idle(1'b1);
        idle(1'b0);
        chk("drain_idle", 32'(busy[cur_i]), 32'd0);
    endtask

    // Single operation with latency measurement, then the handshake.
    task automatic lat_op(input logic [2:0] op, input logic [3:0] bb, input logic [3:0] cc,
                          input logic [3:0] tg, input logic [7:0] exp_res);
        int n;
        issue(op, bb, cc, tg, 1'b0);
        n = 0;
        do begin
            idle(1'b0);
            n++;
        end while (rsp_valid[cur_i] !== 1'b1 && n < 40);
        chk("latency",        32'(n - 1),                32'(cur_L + 1));
        chk("single_result",  32'(rsp_result[cur_i]),    32'(exp_res));
        chk("single_opcode",  32'(rsp_opcode[cur_i]),    32'(op));
        chk("single_tag",     32'(rsp_tag[cur_i]),       32'(tg));
        idle(1'b1);
        idle(1'b0);
    endtask

    task automatic back_to_back();
        int  k, last;
        bit  acc;
        reset_cycle();
        k = 0;
        last = 0;
        for (int t = 0; t < 300 && k < 8; t++) begin
            step(1'b0, 1'b1, 3'(k), 4'($urandom), 4'($urandom), 4'(k + 3), 1'b1, acc);
            if (acc) begin
                if (k > 0) chk("b2b_spacing", 32'(t - last), 32'(cur_L + 2));
                last = t;
                k++;
            end
        end
        chk("b2b_count", 32'(k), 32'd8);
        drain();
        chk("b2b_done", 32'(done_count[cur_i]), 32'd8);
    endtask

    task automatic backpressure();
        bit acc;
        reset_cycle();
        issue(3'd6, 4'd9, 4'd4, 4'd11, 1'b0);
        wait_valid();
        for (int k = 0; k < 10; k++)
            step(1'b0, 1'b1, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, acc);
        chk("bp_result",    32'(rsp_result[cur_i]), 32'h94);
        chk("bp_tag",       32'(rsp_tag[cur_i]),    32'd11);
        chk("bp_alu_b",     32'(b[cur_i]),          32'd9);
        chk("bp_done_held", 32'(done_count[cur_i]), 32'd0);
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b1, acc);
        idle(1'b1);
        chk("bp_one_hs",    32'(done_count[cur_i]), 32'd1);
        chk("bp_valid_low", 32'(rsp_valid[cur_i]),  32'd0);
    endtask

    task automatic reset_checks(input string where);
        chk({where, "_busy"},      32'(busy[cur_i]),       32'd0);
        chk({where, "_rsp_valid"}, 32'(rsp_valid[cur_i]),  32'd0);
        chk({where, "_req_ready"}, 32'(req_ready[cur_i]),  32'd1);
        chk({where, "_done"},      32'(done_count[cur_i]), 32'd0);
        chk({where, "_alu"},       32'({opcode[cur_i], b[cur_i], c[cur_i]}), 32'd0);
        chk({where, "_rsp"},       32'({rsp_result[cur_i], rsp_opcode[cur_i], rsp_tag[cur_i]}), 32'd0);
    endtask

    task automatic reset_mid();
        reset_cycle();
        issue(3'd5, 4'd7, 4'd3, 4'd2, 1'b0);
        reset_cycle();
        idle(1'b0);
        reset_checks("rst_wait");
        for (int k = 0; k < 20; k++) idle(1'b1);
        chk("rst_wait_no_stale", 32'(done_count[cur_i]), 32'd0);

        issue(3'd3, 4'd1, 4'd8, 4'd6, 1'b0);
        wait_valid();
        idle(1'b1);
        issue(3'd2, 4'd12, 4'd5, 4'd9, 1'b0);
        wait_valid();
        chk("rst_resp_pre_done", 32'(done_count[cur_i]), 32'd1);
        reset_cycle();
        idle(1'b1);
        reset_checks("rst_resp");
        for (int k = 0; k < 20; k++) idle(1'b1);
        chk("rst_resp_no_stale", 32'(done_count[cur_i]), 32'd0);
    endtask

    task automatic counter_wrap();
        int k;
        bit acc;
        reset_cycle();
        k = 0;
        for (int t = 0; t < 4000 && k < 256; t++) begin
            step(1'b0, 1'b1, 3'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, acc);
            if (acc) k++;
        end
        drain();
        chk("wrap_256", 32'(done_count[cur_i]), 32'd0);
        issue(3'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        drain();
        chk("wrap_257", 32'(done_count[cur_i]), 32'd1);
    endtask

    task automatic random_run(input int n);
        bit acc;
        for (int k = 0; k < n; k++)
            step(($urandom_range(0, 99) == 0), 1'($urandom), 3'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), acc);
    endtask

    task automatic run_inst(input int i);
        cur_i = i;
        cur_L = lat_of(i);
        model_reset();
        reset_cycle();
        idle(1'b0);
        reset_checks("por");
        lat_op(3'b001, 4'd10, 4'd2, 4'd5, 8'hA2);
        chk("single_done", 32'(done_count[cur_i]), 32'd1);
        lat_op(3'($urandom), 4'd15, 4'd15, 4'($urandom), 8'hFF);
        back_to_back();
        backpressure();
        reset_mid();
        if (i == 1) counter_wrap();
        random_run((i == 0) ? 1500 : 400);
        reset_cycle();
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset[i]      = 1'b1;
            req_valid[i]  = 1'b0;
            req_opcode[i] = 3'd0;
            req_b[i]      = 4'd0;
            req_c[i]      = 4'd0;
            req_tag[i]    = 4'd0;
            rsp_ready[i]  = 1'b0;
        end
        for (int i = 0; i < NI; i++) run_inst(i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
